l2_line_writer: RTL and testbench

- Write-side counterpart of the L2 hit/miss lookup. Once the L2 controller has resolved a request, fill, forward or eviction, this block takes one line-update command and serialises it into per-word writes to the L2 tag and state arrays.
- It writes the tag and the new per-word Spandex states for the chosen set and way.
- It reports completion, and reports whether the written line ends with every word in SPX_I, so the controller can treat the way as empty.

---
 rtl/l2_line_writer_if.sv | 49 ++++
 rtl/l2_line_writer.sv | 182 ++++++++++++++++++
 tb/tb_l2_line_writer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/l2_line_writer_if.sv
// Command / write-port bundle of the L2 line writer.
//   master: the L2 controller side (drives req_*, receives ready, writes, done)
//   slave : the line writer itself
// Signals: req_valid/req_ready handshake, req_mode/set/way/tag/word_mask/
// states/cur_states command fields, wr_* tag/state array write port,
// done_valid/done_line_empty completion report.
interface l2_line_writer_if #(
  parameter int WORDS      = 4,
  parameter int WAY_BITS   = 3,
  parameter int WORD_BITS  = 2,
  parameter int SET_BITS   = 9,
  parameter int TAG_BITS   = 16,
  parameter int STATE_BITS = 3
);
  logic                        req_valid;
  logic                        req_ready;
  logic [1:0]                  req_mode;
  logic [SET_BITS-1:0]         req_set;
  logic [WAY_BITS-1:0]         req_way;
  logic [TAG_BITS-1:0]         req_tag;
  logic [WORDS-1:0]            req_word_mask;
  logic [WORDS*STATE_BITS-1:0] req_states;
  logic [WORDS*STATE_BITS-1:0] req_cur_states;

  logic                        wr_tag_en;
  logic [TAG_BITS-1:0]         wr_tag_data;
  logic                        wr_state_en;
  logic [STATE_BITS-1:0]       wr_state_data;
  logic [SET_BITS-1:0]         wr_set;
  logic [WAY_BITS-1:0]         wr_way;
  logic [WORD_BITS-1:0]        wr_word;

  logic                        done_valid;
  logic                        done_line_empty;

  modport master (
    output req_valid, req_mode, req_set, req_way, req_tag, req_word_mask,
           req_states, req_cur_states,
    input  req_ready, wr_tag_en, wr_tag_data, wr_state_en, wr_state_data,
           wr_set, wr_way, wr_word, done_valid, done_line_empty
  );

  modport slave (
    input  req_valid, req_mode, req_set, req_way, req_tag, req_word_mask,
           req_states, req_cur_states,
    output req_ready, wr_tag_en, wr_tag_data, wr_state_en, wr_state_data,
           wr_set, wr_way, wr_word, done_valid, done_line_empty
  );
endinterface

// File: rtl/l2_line_writer.sv
// L2 line writer: takes one line-update command (FILL / UPDATE / INVALIDATE)
// and serialises it into one tag write (FILL only) followed by one state
// write per pending word, then pulses done with a line-empty indication.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - l2_line_writer_if.slave (command handshake, array write port, done)
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | ready for a command
// ST_TAG   | FILL only: tag array write
// ST_WORDS | one state write per pending word, lowest first
// ST_DONE  | one-cycle completion pulse
module l2_line_writer #(
  parameter int WAYS       = 8,
  parameter int WORDS      = 4,
  parameter int WAY_BITS   = 3,
  parameter int WORD_BITS  = 2,
  parameter int SET_BITS   = 9,
  parameter int TAG_BITS   = 16,
  parameter int STATE_BITS = 3,
  parameter int SPX_I_VAL  = 0
) (
  input logic              clk,
  input logic              rst,
  l2_line_writer_if.slave  bus
);
  if ((1 << WAY_BITS) != WAYS) begin : g_bad_way_bits
    $error("WAY_BITS must equal log2(WAYS)");
  end

  localparam logic [STATE_BITS-1:0] SPX_I = STATE_BITS'(SPX_I_VAL);
  localparam logic [1:0] MODE_FILL   = 2'd0;
  localparam logic [1:0] MODE_UPDATE = 2'd1;
  localparam logic [1:0] MODE_INVAL  = 2'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_TAG, ST_WORDS, ST_DONE} state_t;

  state_t                 state_q, state_d;
  logic [SET_BITS-1:0]    set_q;
  logic [WAY_BITS-1:0]    way_q;
  logic [TAG_BITS-1:0]    tag_q;
  logic [WORDS-1:0]       pend_q;
  logic [STATE_BITS-1:0]  final_q [WORDS];
  logic                   empty_q;

  logic [TAG_BITS-1:0]    last_tag;
  logic [STATE_BITS-1:0]  last_state;
  logic [SET_BITS-1:0]    last_set;
  logic [WAY_BITS-1:0]    last_way;
  logic [WORD_BITS-1:0]   last_word;

  logic [WORDS-1:0]       acc_mask;
  logic [STATE_BITS-1:0]  acc_final [WORDS];
  logic                   acc_empty;
  logic [WORD_BITS-1:0]   sel;
  logic [WORDS-1:0]       sel_oh;
  logic                   accept, tag_en, st_en, done;

  // Final per-word states and pending mask, evaluated on the live request.
  always_comb begin
    acc_mask  = '0;
    acc_empty = 1'b1;
    for (int j = 0; j < WORDS; j++) begin
      acc_final[j] = bus.req_cur_states[j*STATE_BITS +: STATE_BITS];
      case (bus.req_mode)
        MODE_FILL: begin
          acc_mask[j]  = 1'b1;
          acc_final[j] = bus.req_word_mask[j] ?
                         bus.req_states[j*STATE_BITS +: STATE_BITS] : SPX_I;
        end
        MODE_UPDATE: begin
          acc_mask[j] = bus.req_word_mask[j];
          if (bus.req_word_mask[j])
            acc_final[j] = bus.req_states[j*STATE_BITS +: STATE_BITS];
        end
        MODE_INVAL: begin
          acc_mask[j] = bus.req_word_mask[j];
          if (bus.req_word_mask[j])
            acc_final[j] = SPX_I;
        end
        default: ;
      endcase
      if (acc_final[j] != SPX_I)
        acc_empty = 1'b0;
    end
  end

  // Lowest pending word.
  always_comb begin
    sel = '0;
    for (int j = WORDS - 1; j >= 0; j--)
      if (pend_q[j])
        sel = WORD_BITS'(j);
  end
  assign sel_oh = WORDS'(1) << sel;

  assign accept = bus.req_valid && (state_q == ST_IDLE);

  // Strobes are gated by rst so an abort is visible in the reset cycle itself.
  always_comb begin
    state_d = state_q;
    tag_en  = 1'b0;
    st_en   = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (bus.req_mode == MODE_FILL) state_d = ST_TAG;
          else if (acc_mask != '0)      state_d = ST_WORDS;
          else                          state_d = ST_DONE;
        end
      end
      ST_TAG: begin
        tag_en  = !rst;
        state_d = ST_WORDS;
      end
      ST_WORDS: begin
        st_en = !rst;
        if ((pend_q & ~sel_oh) == '0)
          state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = !rst;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      set_q      <= '0;
      way_q      <= '0;
      tag_q      <= '0;
      pend_q     <= '0;
      final_q    <= '{default: '0};
      empty_q    <= 1'b0;
      last_tag   <= '0;
      last_state <= '0;
      last_set   <= '0;
      last_way   <= '0;
      last_word  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        set_q   <= bus.req_set;
        way_q   <= bus.req_way;
        tag_q   <= bus.req_tag;
        pend_q  <= acc_mask;
        final_q <= acc_final;
        empty_q <= acc_empty;
      end else if (st_en) begin
        pend_q <= pend_q & ~sel_oh;
      end
      if (tag_en)
        last_tag <= tag_q;
      if (tag_en || st_en) begin
        last_set <= set_q;
        last_way <= way_q;
      end
      if (st_en) begin
        last_word  <= sel;
        last_state <= final_q[sel];
      end
    end
  end

  // Write-port fields show live values during a strobe, else the last written.
  assign bus.req_ready       = (state_q == ST_IDLE);
  assign bus.wr_tag_en       = tag_en;
  assign bus.wr_state_en     = st_en;
  assign bus.wr_tag_data     = tag_en ? tag_q : last_tag;
  assign bus.wr_state_data   = st_en ? final_q[sel] : last_state;
  assign bus.wr_set          = (tag_en || st_en) ? set_q : last_set;
  assign bus.wr_way          = (tag_en || st_en) ? way_q : last_way;
  assign bus.wr_word         = st_en ? sel : last_word;
  assign bus.done_valid      = done;
  assign bus.done_line_empty = done && empty_q;
endmodule

// File: tb/tb_l2_line_writer.sv
module tb_l2_line_writer;
  localparam logic [2:0] SI = 3'd0, SV = 3'd1, SS = 3'd2, SR = 3'd3;
  localparam logic [1:0] M_FILL = 2'd0, M_UPD = 2'd1, M_INV = 2'd2, M_RSV = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  l2_line_writer_if bus ();
  l2_line_writer dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] mode, input logic [8:0] set, input logic [2:0] way,
                       input logic [15:0] tag, input logic [3:0] mask,
                       input logic [11:0] states, input logic [11:0] cur);
    bus.req_valid      = 1'b1;
    bus.req_mode       = mode;
    bus.req_set        = set;
    bus.req_way        = way;
    bus.req_tag        = tag;
    bus.req_word_mask  = mask;
    bus.req_states     = states;
    bus.req_cur_states = cur;
  endtask

  // Garbage on every field while busy; must not disturb the running command.
  task automatic scramble();
    bus.req_valid      = 1'b0;
    bus.req_mode       = M_UPD;
    bus.req_set        = 9'h1C3;
    bus.req_way        = 3'd6;
    bus.req_tag        = 16'hDEAD;
    bus.req_word_mask  = 4'b1111;
    bus.req_states     = {SV, SV, SV, SV};
    bus.req_cur_states = {SR, SR, SR, SR};
  endtask

  // Called at a negedge; returns just after the accepting posedge.
  task automatic await_accept();
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.req_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("accept", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Observe one command from the cycle after acceptance through done.
  task automatic collect(input bit exp_tag, input logic [15:0] etag, input logic [8:0] eset,
                         input logic [2:0] eway, input int en, input logic [7:0] ewords,
                         input logic [11:0] edata, input int elat, input bit eempty);
    int ntag = 0;
    int nst  = 0;
    bit seen = 1'b0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(negedge clk);
      chk("overlap", 32'(bus.wr_tag_en & bus.wr_state_en), 32'd0);
      if (c == 1) chk("ready_busy", 32'(bus.req_ready), 32'd0);
      if (bus.wr_tag_en) begin
        ntag++;
        chk("tag_cycle", 32'(c), 32'd1);
        chk("tag_data", 32'(bus.wr_tag_data), 32'(etag));
        chk("tag_set", 32'(bus.wr_set), 32'(eset));
        chk("tag_way", 32'(bus.wr_way), 32'(eway));
      end
      if (bus.wr_state_en) begin
        if (nst < en) begin
          chk("st_word", 32'(bus.wr_word), 32'(ewords[nst*2 +: 2]));
          chk("st_data", 32'(bus.wr_state_data), 32'(edata[nst*3 +: 3]));
          chk("st_set", 32'(bus.wr_set), 32'(eset));
          chk("st_way", 32'(bus.wr_way), 32'(eway));
        end
        nst++;
      end
      if (bus.done_valid) begin
        seen = 1'b1;
        chk("done_lat", 32'(c), 32'(elat));
        chk("done_empty", 32'(bus.done_line_empty), 32'(eempty));
        if (en > 0) begin
          chk("hold_word", 32'(bus.wr_word), 32'(ewords[(en-1)*2 +: 2]));
          chk("hold_data", 32'(bus.wr_state_data), 32'(edata[(en-1)*3 +: 3]));
        end
        if (exp_tag) chk("hold_tag", 32'(bus.wr_tag_data), 32'(etag));
      end else begin
        chk("empty_low", 32'(bus.done_line_empty), 32'd0);
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("n_tag", 32'(ntag), 32'(exp_tag));
    chk("n_state", 32'(nst), 32'(en));
    if (seen) begin
      @(negedge clk);
      chk("ready_after", 32'(bus.req_ready), 32'd1);
      chk("single_done", 32'(bus.done_valid), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit any;
    scramble();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tag_en", 32'(bus.wr_tag_en), 32'd0);
    chk("rst_st_en", 32'(bus.wr_state_en), 32'd0);
    chk("rst_done", 32'(bus.done_valid), 32'd0);
    chk("rst_wr_set", 32'(bus.wr_set), 32'd0);
    chk("rst_tag_data", 32'(bus.wr_tag_data), 32'd0);
    chk("rst_empty", 32'(bus.done_line_empty), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'd1);

    // FILL: words 0..3 -> R, I, V, I
    drive(M_FILL, 9'h05A, 3'd3, 16'h1234, 4'b0101, {SR, SV, SS, SR}, {SS, SS, SS, SS});
    await_accept(); scramble();
    collect(1, 16'h1234, 9'h05A, 3'd3, 4, {2'd3, 2'd2, 2'd1, 2'd0}, {SI, SV, SI, SR}, 6, 0);

    // UPDATE mask 1010
    drive(M_UPD, 9'h0F0, 3'd2, 16'h0000, 4'b1010, {SV, SR, SR, SR}, {SS, SS, SS, SS});
    await_accept(); scramble();
    collect(0, 16'h1234, 9'h0F0, 3'd2, 2, {2'd0, 2'd0, 2'd3, 2'd1}, {3'd0, 3'd0, SV, SR}, 3, 0);

    // INVALIDATE mask 0110, line becomes empty
    drive(M_INV, 9'h003, 3'd4, 16'h0000, 4'b0110, {SR, SR, SR, SR}, {SI, SR, SS, SI});
    await_accept(); scramble();
    collect(0, 16'h1234, 9'h003, 3'd4, 2, {2'd0, 2'd0, 2'd2, 2'd1}, {3'd0, 3'd0, SI, SI}, 3, 1);

    // INVALIDATE again, word 0 still S
    drive(M_INV, 9'h003, 3'd4, 16'h0000, 4'b0110, {SR, SR, SR, SR}, {SI, SR, SS, SS});
    await_accept(); scramble();
    collect(0, 16'h1234, 9'h003, 3'd4, 2, {2'd0, 2'd0, 2'd2, 2'd1}, {3'd0, 3'd0, SI, SI}, 3, 0);

    // UPDATE with empty mask
    drive(M_UPD, 9'h001, 3'd1, 16'h0000, 4'b0000, {SR, SR, SR, SR}, {SS, SS, SS, SS});
    await_accept(); scramble();
    collect(0, 16'h1234, 9'h003, 3'd4, 0, 8'h0, 12'h0, 1, 0);

    // Reserved mode, all-I line
    drive(M_RSV, 9'h001, 3'd1, 16'hFFFF, 4'b1111, {SR, SR, SR, SR}, {SI, SI, SI, SI});
    await_accept(); scramble();
    collect(0, 16'h1234, 9'h003, 3'd4, 0, 8'h0, 12'h0, 1, 1);

    // FILL with empty mask: every word written I, line empty
    drive(M_FILL, 9'h100, 3'd0, 16'h0001, 4'b0000, {SR, SR, SR, SR}, {SS, SS, SS, SS});
    await_accept(); scramble();
    collect(1, 16'h0001, 9'h100, 3'd0, 4, {2'd3, 2'd2, 2'd1, 2'd0}, {SI, SI, SI, SI}, 6, 1);

    // Reset during the second WORDS cycle of a FILL
    drive(M_FILL, 9'h0AA, 3'd5, 16'h5555, 4'b1111, {SR, SR, SR, SR}, {SS, SS, SS, SS});
    await_accept(); scramble();
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_now", 32'(bus.wr_state_en | bus.wr_tag_en | bus.done_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    any = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) chk("ready_post_rst", 32'(bus.req_ready), 32'd1);
      any |= bus.wr_tag_en | bus.wr_state_en | bus.done_valid;
    end
    chk("abort_quiet", 32'(any), 32'd0);
    chk("abort_word_clr", 32'(bus.wr_word), 32'd0);

    drive(M_UPD, 9'h022, 3'd2, 16'h0000, 4'b1000, {SR, SS, SS, SS}, {SI, SI, SI, SI});
    await_accept(); scramble();
    collect(0, 16'h0000, 9'h022, 3'd2, 1, {2'd0, 2'd0, 2'd0, 2'd3}, {3'd0, 3'd0, 3'd0, SR}, 2, 0);

    // Three commands with req_valid held high; next fields applied while busy
    drive(M_UPD, 9'h011, 3'd1, 16'h0000, 4'b0011, {SR, SR, SR, SV}, {SS, SS, SS, SS});
    await_accept();
    drive(M_INV, 9'h044, 3'd6, 16'h7777, 4'b1111, {SR, SR, SR, SR}, {SS, SS, SS, SS});
    collect(0, 16'h0000, 9'h011, 3'd1, 2, {2'd0, 2'd0, 2'd1, 2'd0}, {3'd0, 3'd0, SR, SV}, 3, 0);
    await_accept();
    drive(M_FILL, 9'h1FF, 3'd7, 16'hBEEF, 4'b1000, {SS, SR, SR, SR}, {SS, SS, SS, SS});
    collect(0, 16'h0000, 9'h044, 3'd6, 4, {2'd3, 2'd2, 2'd1, 2'd0}, {SI, SI, SI, SI}, 5, 1);
    await_accept(); scramble();
    collect(1, 16'hBEEF, 9'h1FF, 3'd7, 4, {2'd3, 2'd2, 2'd1, 2'd0}, {SS, SI, SI, SI}, 6, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
